// File: rtl/sseg_capture.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus: synchronizes,
// debounces and latches each strobed digit, decodes it to hex and tracks full frames.
module sseg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  sseg_anode,
    input  logic [6:0]  sseg_cathode,
    input  logic        clear,
    output logic [27:0] digit_seg,
    output logic [15:0] digit_hex,
    output logic [3:0]  digit_known,
    output logic        frame_valid,
    output logic        anode_err
);

    localparam int unsigned LP_DIGITS = 4;
    localparam int unsigned LP_SEG_W  = 7;
    localparam int unsigned LP_HEX_W  = 4;
    localparam int unsigned LP_SYNC_W = LP_DIGITS + LP_SEG_W;
    localparam int unsigned LP_CNT_W  = 8;
    localparam logic [LP_CNT_W-1:0] LP_CNT_MAX = LP_CNT_W'(STABLE_CYCLES);
    localparam logic [LP_CNT_W-1:0] LP_CNT_CAP = LP_CNT_W'(STABLE_CYCLES - 1);

    logic [LP_SYNC_W-1:0]           r_sync1;
    logic [LP_SYNC_W-1:0]           r_sync2;
    logic [LP_SYNC_W-1:0]           r_sync2_d;
    logic [LP_CNT_W-1:0]            r_cnt;
    logic [LP_DIGITS*LP_SEG_W-1:0]  r_digit_seg;
    logic [LP_DIGITS*LP_HEX_W-1:0]  r_digit_hex;
    logic [LP_DIGITS-1:0]           r_digit_known;
    logic [LP_DIGITS-1:0]           r_seen;
    logic                           r_frame_valid;
    logic                           r_anode_err;

    logic                 w_changed;
    logic                 w_capture;
    logic [3:0]           w_anode;
    logic [LP_SEG_W-1:0]  w_seg;
    logic [LP_DIGITS-1:0] w_onehot;
    logic                 w_bad;
    logic [LP_DIGITS-1:0] w_cap_bit;
    logic                 w_err_cap;
    logic [4:0]           w_dec;
    logic [LP_DIGITS-1:0] w_seen_next;

    // Pattern to {known, nibble} against the gfedcba active-high hex table
    function automatic logic [4:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    assign w_changed = (r_sync2 != r_sync2_d);
    assign w_capture = !w_changed && (r_cnt == LP_CNT_CAP);
    assign w_anode   = r_sync2_d[LP_SYNC_W-1 -: LP_DIGITS];
    assign w_seg     = ~r_sync2_d[LP_SEG_W-1:0];
    assign w_dec     = f_decode(w_seg);

    always_comb begin
        w_onehot = '0;
        w_bad    = 1'b0;
        case (w_anode)
            4'b1110: w_onehot = 4'b0001;
            4'b1101: w_onehot = 4'b0010;
            4'b1011: w_onehot = 4'b0100;
            4'b0111: w_onehot = 4'b1000;
            4'b1111: w_bad    = 1'b0;
            default: w_bad    = 1'b1;
        endcase
    end

    assign w_cap_bit   = {LP_DIGITS{w_capture}} & w_onehot;
    assign w_err_cap   = w_capture & w_bad;
    assign w_seen_next = (clear ? '0 : r_seen) | w_cap_bit;

    // Input synchronizer and stability counter; idle value equals reset so it never captures
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= '1;
            r_sync2   <= '1;
            r_sync2_d <= '1;
            r_cnt     <= LP_CNT_MAX;
        end else begin
            r_sync1   <= {sseg_anode, sseg_cathode};
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
            if (w_changed) begin
                r_cnt <= '0;
            end else if (r_cnt != LP_CNT_MAX) begin
                r_cnt <= r_cnt + LP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digit_seg   <= '0;
            r_digit_hex   <= '0;
            r_digit_known <= '0;
        end else begin
            for (int unsigned i = 0; i < LP_DIGITS; i++) begin
                if (w_cap_bit[i]) begin
                    r_digit_seg[i*LP_SEG_W +: LP_SEG_W] <= w_seg;
                    r_digit_hex[i*LP_HEX_W +: LP_HEX_W] <= w_dec[3:0];
                    r_digit_known[i]                    <= w_dec[4];
                end
            end
        end
    end

    // Frame mask and sticky error; an illegal capture beats a coincident clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seen        <= '0;
            r_frame_valid <= 1'b0;
            r_anode_err   <= 1'b0;
        end else begin
            if (&w_seen_next) begin
                r_frame_valid <= 1'b1;
                r_seen        <= '0;
            end else begin
                r_frame_valid <= 1'b0;
                r_seen        <= w_seen_next;
            end
            if (w_err_cap) begin
                r_anode_err <= 1'b1;
            end else if (clear) begin
                r_anode_err <= 1'b0;
            end
        end
    end

    assign digit_seg   = r_digit_seg;
    assign digit_hex   = r_digit_hex;
    assign digit_known = r_digit_known;
    assign frame_valid = r_frame_valid;
    assign anode_err   = r_anode_err;

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture: a reference model predicts each capture,
// queues it, and checks it on the exact capture edge.
module tb_sseg_capture;

    localparam int unsigned S = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  sseg_anode;
    logic [6:0]  sseg_cathode;
    logic        clear;
    logic [27:0] digit_seg;
    logic [15:0] digit_hex;
    logic [3:0]  digit_known;
    logic        frame_valid;
    logic        anode_err;

    sseg_capture #(.STABLE_CYCLES(S)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sseg_anode   (sseg_anode),
        .sseg_cathode (sseg_cathode),
        .clear        (clear),
        .digit_seg    (digit_seg),
        .digit_hex    (digit_hex),
        .digit_known  (digit_known),
        .frame_valid  (frame_valid),
        .anode_err    (anode_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [27:0] seg;
        logic [15:0] hex;
        logic [3:0]  known;
        logic        err;
        logic        fv;
    } exp_t;

    exp_t        sb_q[$];
    logic [27:0] m_seg;
    logic [15:0] m_hex;
    logic [3:0]  m_known;
    logic        m_err;
    logic [3:0]  m_seen;
    int          checks = 0;
    int          errors = 0;
    int          fv_count = 0;
    int          fv_base;
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always @(negedge clk) if (frame_valid === 1'b1) fv_count++;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_seg"},   32'(digit_seg),   32'(m_seg));
        chk({tag, "_hex"},   32'(digit_hex),   32'(m_hex));
        chk({tag, "_known"}, 32'(digit_known), 32'(m_known));
        chk({tag, "_err"},   32'(anode_err),   32'(m_err));
        chk({tag, "_fv"},    32'(frame_valid), 32'(1'b0));
    endtask

    task automatic model_reset;
        m_seg = '0; m_hex = '0; m_known = '0; m_err = 1'b0; m_seen = '0;
    endtask

    task automatic predict(input logic [3:0] an, input logic [6:0] cat, input bit clr,
                           output exp_t e, output logic [3:0] nseen);
        logic [3:0] bitv;
        logic [6:0] seg;
        logic [3:0] sn;
        bit         illegal;
        seg = ~cat;
        bitv = '0;
        illegal = 1'b0;
        case (an)
            4'b1110: bitv = 4'b0001;
            4'b1101: bitv = 4'b0010;
            4'b1011: bitv = 4'b0100;
            4'b0111: bitv = 4'b1000;
            4'b1111: illegal = 1'b0;
            default: illegal = 1'b1;
        endcase
        e.seg = m_seg; e.hex = m_hex; e.known = m_known;
        e.err = illegal ? 1'b1 : (clr ? 1'b0 : m_err);
        for (int n = 0; n < 4; n++) begin
            if (bitv[n]) begin
                e.seg[7*n +: 7] = seg;
                e.hex[4*n +: 4] = 4'h0;
                e.known[n] = 1'b0;
                for (int v = 0; v < 16; v++) begin
                    if (hex_tab[v] == seg) begin
                        e.hex[4*n +: 4] = 4'(v);
                        e.known[n] = 1'b1;
                    end
                end
            end
        end
        sn = (clr ? 4'b0000 : m_seen) | bitv;
        e.fv = (sn == 4'hF);
        nseen = e.fv ? 4'h0 : sn;
    endtask

    // Drive one bus value for 'hold' cycles; values held longer than S are captured
    task automatic step(input logic [3:0] an, input logic [6:0] cat, input int hold,
                        input bit clr_at_cap, input string tag);
        exp_t       e;
        logic [3:0] nseen;
        bit         cap;
        cap = (hold > int'(S));
        sseg_anode = an;
        sseg_cathode = cat;
        nseen = m_seen;
        if (cap) begin
            predict(an, cat, clr_at_cap, e, nseen);
            sb_q.push_back(e);
        end
        for (int k = 1; k <= hold; k++) begin
            tick;
            if (cap && k == int'(2 + S)) begin
                check_state({tag, "_pre"});
                if (clr_at_cap) clear = 1'b1;
            end
            if (cap && k == int'(3 + S)) begin
                clear = 1'b0;
                chk({tag, "_sbq"}, 32'(sb_q.size() > 0), 32'(1));
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk({tag, "_cap_seg"},   32'(digit_seg),   32'(e.seg));
                    chk({tag, "_cap_hex"},   32'(digit_hex),   32'(e.hex));
                    chk({tag, "_cap_known"}, 32'(digit_known), 32'(e.known));
                    chk({tag, "_cap_err"},   32'(anode_err),   32'(e.err));
                    chk({tag, "_cap_fv"},    32'(frame_valid), 32'(e.fv));
                    m_seg = e.seg; m_hex = e.hex; m_known = e.known; m_err = e.err;
                    m_seen = nseen;
                end
            end
            if (cap && k == int'(4 + S)) chk({tag, "_fv_drop"}, 32'(frame_valid), 32'(1'b0));
        end
        check_state({tag, "_end"});
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        m_err = 1'b0;
        m_seen = '0;
        check_state("clear");
    endtask

    initial begin
        reset_n = 1'b0;
        sseg_anode = 4'b1111;
        sseg_cathode = 7'h7F;
        clear = 1'b0;
        model_reset();
        #12;
        check_state("reset");
        tick;
        reset_n = 1'b1;

        // Idle bus: nothing captured, no frame
        repeat (100) tick;
        check_state("idle");
        chk("idle_fv_count", 32'(fv_count), 32'(0));

        // Frame 0,1,2,3
        fv_base = fv_count;
        step(4'b1110, ~7'h3F, 20, 1'b0, "fa_d0");
        step(4'b1101, ~7'h06, 20, 1'b0, "fa_d1");
        step(4'b1011, ~7'h5B, 20, 1'b0, "fa_d2");
        step(4'b0111, ~7'h4F, 20, 1'b0, "fa_d3");
        chk("fa_hex", 32'(digit_hex), 32'(16'h3210));
        chk("fa_known", 32'(digit_known), 32'(4'hF));
        chk("fa_seg0", 32'(digit_seg[6:0]), 32'(7'h3F));
        chk("fa_fv_count", 32'(fv_count - fv_base), 32'(1));

        // Glitched digit 1 must not enter the mask
        fv_base = fv_count;
        step(4'b1110, ~7'h66, 20, 1'b0, "gl_d0");
        step(4'b1101, ~7'h7F, 3,  1'b0, "gl_glitch");
        step(4'b1111, 7'h7F,  20, 1'b0, "gl_blank");
        step(4'b1011, ~7'h6D, 20, 1'b0, "gl_d2");
        step(4'b0111, ~7'h7D, 20, 1'b0, "gl_d3");
        chk("gl_no_frame", 32'(fv_count - fv_base), 32'(0));
        step(4'b1101, ~7'h07, 20, 1'b0, "gl_d1");
        chk("gl_frame", 32'(fv_count - fv_base), 32'(1));
        chk("gl_hex", 32'(digit_hex), 32'(16'h6574));

        // Illegal anode is sticky through a legal frame until clear
        step(4'b1100, ~7'h3F, 10, 1'b0, "il_bad");
        chk("il_err", 32'(anode_err), 32'(1'b1));
        step(4'b1110, ~7'h07, 20, 1'b0, "il_d0");
        step(4'b1101, ~7'h7F, 20, 1'b0, "il_d1");
        step(4'b1011, ~7'h6F, 20, 1'b0, "il_d2");
        step(4'b0111, ~7'h77, 20, 1'b0, "il_d3");
        chk("il_err_sticky", 32'(anode_err), 32'(1'b1));
        chk("il_hex", 32'(digit_hex), 32'(16'hA987));
        do_clear();
        chk("il_cleared", 32'(anode_err), 32'(1'b0));
        step(4'b1001, ~7'h06, 12, 1'b1, "il_clr_coinc");
        chk("il_coinc_err", 32'(anode_err), 32'(1'b1));

        // Unknown pattern on digit 2 still completes the frame
        fv_base = fv_count;
        step(4'b1011, ~7'h49, 20, 1'b0, "uk_d2");
        step(4'b1110, ~7'h7C, 20, 1'b0, "uk_d0");
        step(4'b1101, ~7'h39, 20, 1'b0, "uk_d1");
        step(4'b0111, ~7'h5E, 20, 1'b0, "uk_d3");
        chk("uk_seg2", 32'(digit_seg[20:14]), 32'(7'h49));
        chk("uk_hex2", 32'(digit_hex[11:8]), 32'(4'h0));
        chk("uk_known", 32'(digit_known), 32'(4'b1011));
        chk("uk_frame", 32'(fv_count - fv_base), 32'(1));

        // Reset mid-frame discards the partial frame
        step(4'b1110, ~7'h79, 20, 1'b0, "rs_d0");
        step(4'b1101, ~7'h71, 20, 1'b0, "rs_d1");
        sseg_anode = 4'b1111;
        sseg_cathode = 7'h7F;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_state("rs_async");
        tick;
        reset_n = 1'b1;
        repeat (10) tick;
        check_state("rs_after");
        fv_base = fv_count;
        step(4'b1110, ~7'h3F, 20, 1'b0, "rs2_d0");
        step(4'b1101, ~7'h06, 20, 1'b0, "rs2_d1");
        chk("rs2_partial", 32'(fv_count - fv_base), 32'(0));
        step(4'b1011, ~7'h5B, 20, 1'b0, "rs2_d2");
        step(4'b0111, ~7'h4F, 20, 1'b0, "rs2_d3");
        chk("rs2_one_frame", 32'(fv_count - fv_base), 32'(1));

        chk("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sseg_capture.md
# sseg_capture

Receive-side monitor for the multiplexed 4-digit seven-segment bus. Samples the active-low anode strobes and the cathode segment lines that the display-drive path produces, waits for each strobe to settle, and latches each digit's segment pattern into a per-digit register. It also decodes each pattern back to a hex nibble, flags complete four-digit frames and catches illegal anode patterns. Used on-chip for self-check and readback of the display path, and as the checker endpoint in display-path simulations.

## Interface
- STABLE_CYCLES, 4: cycles anode+cathode must hold unchanged before a capture; legal range 1..255
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- sseg_anode  in  4  active-low digit strobes; bit0 = right digit, bit3 = left digit
- sseg_cathode  in  7  active-low segments, bit0..bit6 = a..g
- clear  in  1  synchronous; clears anode_err and the frame-seen mask
- digit_seg  out  28  captured active-high segment patterns; digit n at [7n+6:7n]
- digit_hex  out  16  decoded nibble; digit n at [4n+3:4n]
- digit_known  out  4  bit n = 1 when digit n's pattern matched the hex table
- frame_valid  out  1  one-cycle pulse when all four digits have been captured since the last pulse or clear
- anode_err  out  1  sticky; a stable illegal anode pattern was seen

## Operation
- Two-flop synchronizer on the 11 input bits {anode, cathode}.
  - Both stages reset to all ones (all digits off, all segments off).
- Change detect: changed = (s2 != s2_d), where s2_d is s2 delayed one cycle; s2_d resets to all ones.
- Stability counter cnt, 8 bits:
  - changed: cnt <= 0.
  - not changed and cnt != STABLE_CYCLES: cnt <= cnt+1.
  - Saturates at STABLE_CYCLES.
  - Resets to STABLE_CYCLES, so the idle value is never captured.
- Capture event: !changed && cnt == STABLE_CYCLES-1.
  - Fires exactly once per stable input value.
- Anode decode at a capture:
  - 1110 selects digit 0, 1101 digit 1, 1011 digit 2, 0111 digit 3.
  - 1111 (blank): no capture, no error.
  - Any other pattern: anode_err <= 1, no register update.
- On a legal capture for digit n:
  - digit_seg[n] <= ~cathode.
  - Pattern decoded against the gfedcba active-high table:
    - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
    - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Match: digit_hex[n] <= value, digit_known[n] <= 1.
  - No match: digit_hex[n] <= 0, digit_known[n] <= 0.
- Frame tracking via a 4-bit seen mask:
  - seen_next = (clear ? 0 : seen) | capture_bit.
  - When seen_next == 1111: frame_valid <= 1 for one cycle and seen <= 0.
  - Otherwise seen <= seen_next.
- Recapturing the same digit before the frame completes overwrites its registers; the mask is unchanged.
- clear and an illegal-pattern capture in the same cycle: anode_err set wins (ends at 1).
- Reset mid-operation: every register returns to its reset value immediately (asynchronous); the partial frame is discarded.

## Timing
- Reset values:
  - digit_seg = 0, digit_hex = 0, digit_known = 0, frame_valid = 0, anode_err = 0
  - seen = 0, cnt = STABLE_CYCLES
- Capture latency: the first rising edge that samples a new input value is edge 1. digit_seg, digit_hex and digit_known update on edge 3+STABLE_CYCLES.
  - With STABLE_CYCLES = 4, that is edge 7.
- frame_valid asserts on the same edge as the fourth distinct digit's capture and deasserts on the next edge.
- anode_err asserts on the capture edge of the illegal pattern.
- An input value held for fewer than STABLE_CYCLES+1 cycles after synchronization is ignored. Treat it as a glitch or ghosting on the anode transition.
- Minimum refresh dwell supported: STABLE_CYCLES+2 clocks per digit.

## Test plan
- Reset, then idle bus (anode 1111, cathode 7F) for 100 cycles -> all outputs remain 0, no frame_valid.
- STABLE_CYCLES=4: drive anode 1110 with cathode ~3F=40, then 1101/~06, then 1011/~5B, then 0111/~4F, each held 20 cycles -> digit_hex = 16'h3210, digit_known = 1111, digit_seg[0] = 3F. A single frame_valid pulse occurs on the edge of the digit-3 capture, 7 edges after 0111 is first sampled.
- Glitch: hold anode 1110 with cathode 40 for 20 cycles, then drive anode 1101 for 3 cycles only -> digit 1 is not captured and seen stays at 0001. Then hold anode 1101 for 20 cycles -> digit 1 is captured.
- Illegal anode 1100 held for 10 cycles -> anode_err = 1 and stays at 1 through later legal frames. Pulsing clear for one cycle -> anode_err = 0. clear coincident with an illegal capture -> anode_err = 1.
- Unknown pattern: anode 1011 with cathode ~49 held -> digit_seg[2] = 49, digit_hex[2] = 0, digit_known[2] = 0, and the frame still completes.
- Assert reset_n low mid-frame after 2 digits are captured, then release -> all outputs read 0. The next full 4-digit sequence produces exactly one frame_valid.
